mig_seq_eval: RTL and testbench

MIG_SEQ_EVAL -- requirements
Module: mig_seq_eval

---
 rtl/mig_pkg.sv | 22 ++
 rtl/mig_maj3.sv | 21 ++
 rtl/mig_seq_eval.sv | 178 +++++++++++++++++
 tb/tb_mig_seq_eval.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_pkg.sv
// Shared types and default sizing for the majority-inverter-graph sequential evaluator.
package mig_pkg;

    localparam int N_PI_DEF   = 4;
    localparam int DEPTH_DEF  = 64;
    localparam int IW_DEF     = $clog2(1 + N_PI_DEF + DEPTH_DEF);
    localparam int IDX_CONST0 = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_OUT,
        S_DONE
    } state_t;

    // Operand layout at default sizing: inversion flag above the source index.
    typedef struct packed {
        logic              inv;
        logic [IW_DEF-1:0] idx;
    } operand_t;

endpackage

// File: rtl/mig_maj3.sv
// Three-input majority gate with an optional inversion on each input.
module mig_maj3 (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    input  logic [2:0] i_inv,
    output logic       o_y
);

    logic w_a;
    logic w_b;
    logic w_c;

    always_comb begin
        w_a = i_a ^ i_inv[2];
        w_b = i_b ^ i_inv[1];
        w_c = i_c ^ i_inv[0];
        o_y = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
    end

endmodule

// File: rtl/mig_seq_eval.sv
// Sequential MIG evaluator: one programmed majority gate per EVAL cycle, then a
// single output operand is decoded and handed over with a valid/ready handshake.
module mig_seq_eval
    import mig_pkg::*;
#(
    parameter  int N_PI  = N_PI_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int IW    = $clog2(1 + N_PI + DEPTH),
    localparam int OW    = IW + 1,
    localparam int WW    = 3 * OW,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [WW-1:0]   prog_wdata,
    input  logic            cfg_we,
    input  logic [LW-1:0]   cfg_len,
    input  logic [OW-1:0]   cfg_po,
    input  logic            start,
    input  logic [N_PI-1:0] pi,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res,
    output logic            err
);

    state_t              r_state;
    logic                r_busy;
    logic                r_valid;
    logic                r_res;
    logic                r_err;
    logic [LW-1:0]       r_len;
    logic [LW-1:0]       r_run_len;
    logic [LW-1:0]       r_cnt;
    logic [OW-1:0]       r_po;
    logic [OW-1:0]       r_run_po;
    logic [N_PI-1:0]     r_pi;
    logic [WW-1:0]       r_mem [DEPTH];
    logic [DEPTH-1:0]    r_node;

    logic [(1<<IW)-1:0]  w_src;
    logic [WW-1:0]       w_instr;
    logic [OW-1:0]       w_opa;
    logic [OW-1:0]       w_opb;
    logic [OW-1:0]       w_opc;
    logic                w_bad_a;
    logic                w_bad_b;
    logic                w_bad_c;
    logic                w_gate_bad;
    logic                w_va;
    logic                w_vb;
    logic                w_vc;
    logic                w_maj;
    logic                w_po_bad;
    logic                w_po_val;

    // A reference is bad when it names a node not yet written (j >= lim) or lies past the node range.
    function automatic logic f_bad(input logic [IW-1:0] idx, input logic [LW-1:0] lim);
        int unsigned u_idx;
        u_idx = 32'(idx);
        return (u_idx > N_PI + DEPTH) ||
               ((u_idx > N_PI) && (u_idx - N_PI - 1 >= 32'(lim)));
    endfunction

    always_comb begin
        w_src                        = '0;
        w_src[N_PI:1]                = r_pi;
        w_src[N_PI+DEPTH:N_PI+1]     = r_node;
        w_src[IDX_CONST0]            = 1'b0;

        w_instr    = r_mem[r_cnt[AW-1:0]];
        w_opa      = w_instr[WW-1 -: OW];
        w_opb      = w_instr[2*OW-1 -: OW];
        w_opc      = w_instr[OW-1:0];
        w_bad_a    = f_bad(w_opa[IW-1:0], r_cnt);
        w_bad_b    = f_bad(w_opb[IW-1:0], r_cnt);
        w_bad_c    = f_bad(w_opc[IW-1:0], r_cnt);
        w_va       = w_src[w_opa[IW-1:0]] & ~w_bad_a;
        w_vb       = w_src[w_opb[IW-1:0]] & ~w_bad_b;
        w_vc       = w_src[w_opc[IW-1:0]] & ~w_bad_c;
        w_gate_bad = w_bad_a | w_bad_b | w_bad_c;

        w_po_bad   = f_bad(r_run_po[IW-1:0], r_run_len);
        w_po_val   = (w_src[r_run_po[IW-1:0]] & ~w_po_bad) ^ r_run_po[IW];
    end

    mig_maj3 u_maj3 (
        .i_a   (w_va),
        .i_b   (w_vb),
        .i_c   (w_vc),
        .i_inv ({w_opa[IW], w_opb[IW], w_opc[IW]}),
        .o_y   (w_maj)
    );

    // Program memory and node registers deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_IDLE)) begin
            r_mem[prog_addr] <= prog_wdata;
        end
        if (r_state == S_EVAL) begin
            r_node[r_cnt[AW-1:0]] <= w_maj;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_res     <= 1'b0;
            r_err     <= 1'b0;
            r_len     <= '0;
            r_po      <= '0;
            r_run_len <= '0;
            r_run_po  <= '0;
            r_cnt     <= '0;
            r_pi      <= '0;
        end else begin
            if ((prog_we || cfg_we) && (r_state != S_IDLE)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        r_len <= cfg_len;
                        r_po  <= cfg_po;
                        r_err <= 1'b0;
                    end
                    if (start) begin
                        // Snapshot the config so a same-edge cfg_we only affects the next run.
                        r_run_len <= r_len;
                        r_run_po  <= r_po;
                        r_pi      <= pi;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= (r_len != '0) ? S_EVAL : S_OUT;
                    end
                end
                S_EVAL: begin
                    if (w_gate_bad) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == r_run_len - LW'(1)) begin
                        r_state <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + LW'(1);
                    end
                end
                S_OUT: begin
                    r_res   <= w_po_val;
                    r_valid <= 1'b1;
                    if (w_po_bad) begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign res_valid = r_valid;
    assign res       = r_res;
    assign err       = r_err;

endmodule

// File: tb/tb_mig_seq_eval.sv
// Scoreboard bench for mig_seq_eval: expected results are queued at start and checked on res_valid.
module tb_mig_seq_eval;
    import mig_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        prog_we   = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [23:0] prog_wdata = '0;
    logic        cfg_we    = 1'b0;
    logic [6:0]  cfg_len   = '0;
    logic [7:0]  cfg_po    = '0;
    logic        start     = 1'b0;
    logic [3:0]  pi        = '0;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        res_valid;
    logic        res;
    logic        err;

    int          n_chk = 0;
    int          n_bad = 0;
    logic        q_exp[$];

    logic [23:0] m_mem [64];
    int          m_len = 0;
    logic [7:0]  m_po  = '0;

    logic [6:0]  alt_len = '0;
    logic [7:0]  alt_po  = '0;
    logic [23:0] alt_w   = '0;

    always #5 clk = ~clk;

    mig_seq_eval #(.N_PI(4), .DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .cfg_we     (cfg_we),
        .cfg_len    (cfg_len),
        .cfg_po     (cfg_po),
        .start      (start),
        .pi         (pi),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res        (res),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic operand_t op(input bit inv, input int idx);
        operand_t o;
        o.inv = inv;
        o.idx = 7'(idx);
        return o;
    endfunction

    function automatic logic dec(input logic [7:0] o, input int lim, input logic [3:0] p,
                                 input logic [63:0] nd);
        int   idx;
        logic v;
        idx = int'(o[6:0]);
        if (idx == 0)            v = 1'b0;
        else if (idx <= 4)       v = p[idx-1];
        else if (idx - 5 < lim)  v = nd[idx-5];
        else                     v = 1'b0;
        return v ^ o[7];
    endfunction

    function automatic logic mdl(input logic [3:0] p);
        logic [63:0] nd;
        logic [23:0] w;
        logic        a, b, c;
        nd = '0;
        for (int k = 0; k < m_len; k++) begin
            w = m_mem[k];
            a = dec(w[23:16], k, p, nd);
            b = dec(w[15:8],  k, p, nd);
            c = dec(w[7:0],   k, p, nd);
            nd[k] = (a & b) | (a & c) | (b & c);
        end
        return dec(m_po, m_len, p, nd);
    endfunction

    task automatic prog(input int a, input logic [23:0] w);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 6'(a); prog_wdata = w;
        @(negedge clk);
        prog_we = 1'b0;
        m_mem[a] = w;
    endtask

    task automatic cfg(input int len, input logic [7:0] po);
        @(negedge clk);
        cfg_we = 1'b1; cfg_len = 7'(len); cfg_po = po;
        @(negedge clk);
        cfg_we = 1'b0;
        m_len = len; m_po = po;
    endtask

    // mode 0: plain run; 1: program write attempted during EVAL; 2: cfg_we on the start edge
    task automatic run(input logic [3:0] p, input logic e, input int lat, input int hold, input int mode);
        int n;
        bit seen;
        @(negedge clk);
        pi = p; start = 1'b1;
        if (mode == 2) begin
            cfg_we = 1'b1; cfg_len = alt_len; cfg_po = alt_po;
        end
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; cfg_we = 1'b0; pi = ~p;
        if (mode == 2) begin
            m_len = int'(alt_len); m_po = alt_po;
        end
        chk("busy_run", 32'(busy), 32'(1));
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n == 1) begin
                prog_we = 1'b1; prog_addr = 6'd7; prog_wdata = alt_w;
            end
            if (mode == 1 && n == 2) begin
                prog_we = 1'b0;
                chk("err_busy_wr", 32'(err), 32'(1));
            end
            seen = res_valid;
        end
        if (!seen) begin
            chk("timeout", 32'(seen), 32'(1));
            void'(q_exp.pop_front());
        end else begin
            chk("latency", 32'(n), 32'(lat));
            chk("res", 32'(res), 32'(q_exp.pop_front()));
            for (int i = 0; i < hold; i++) begin
                start = (i % 2 == 0) && (i < hold - 1);
                chk("hold_vld", 32'(res_valid), 32'(1));
                chk("hold_res", 32'(res), 32'(e));
                @(negedge clk);
            end
            start = 1'b0;
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            chk("idle_busy", 32'(busy), 32'(0));
            chk("idle_vld", 32'(res_valid), 32'(0));
            if (hold > 0) begin
                @(posedge clk);
                #1;
                chk("no_rerun", 32'(busy), 32'(0));
            end
        end
        pi = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [23:0] cw;
        logic [3:0]  pv;
        int          ln;

        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_vld",  32'(res_valid), 32'(0));
        chk("rst_res",  32'(res), 32'(0));
        chk("rst_err",  32'(err), 32'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // g0 = MAJ(pi0, pi1, ~c0) = pi0 | pi1
        prog(0, {op(0, 1), op(0, 2), op(1, 0)});
        cfg(1, op(0, 5));
        run(4'b0001, 1'b1, 3, 0, 0);
        run(4'b0000, 1'b0, 3, 0, 0);

        cfg(0, op(1, 3));
        run(4'b0100, 1'b0, 2, 0, 0);
        run(4'b1011, 1'b1, 2, 0, 0);

        // XOR from AND, NOR and MAJ(~and, ~nor, 0)
        prog(0, {op(0, 1), op(0, 2), op(0, 0)});
        prog(1, {op(1, 1), op(1, 2), op(0, 0)});
        prog(2, {op(1, 5), op(1, 6), op(0, 0)});
        cfg(3, op(0, 7));
        for (int i = 0; i < 4; i++) begin
            pv = 4'(i);
            run(pv, pv[0] ^ pv[1], 5, 0, 0);
        end
        chk("err_clean", 32'(err), 32'(0));

        run(4'b0010, 1'b1, 5, 10, 0);

        // start and cfg_we on one edge: this run still uses XOR, the next uses po = pi0
        alt_len = 7'd0; alt_po = op(0, 1);
        run(4'b0011, 1'b0, 5, 0, 2);
        run(4'b0011, 1'b1, 2, 0, 0);

        // g0 names node0 (itself): it reads 0, so g0 = pi0 & pi1
        prog(0, {op(0, 5), op(0, 1), op(0, 2)});
        cfg(1, op(0, 5));
        run(4'b0011, 1'b1, 3, 0, 0);
        chk("err_fwd", 32'(err), 32'(1));
        cfg(1, op(0, 5));
        chk("err_clr", 32'(err), 32'(0));

        for (int k = 0; k < 8; k++) begin
            if (k == 0) cw = {op(0, 1), op(0, 2), op(0, 3)};
            else        cw = {op(0, 4 + k), op(1'(k & 1), 1 + (k % 4)), op(0, 1 + ((k + 1) % 4))};
            prog(k, cw);
        end
        cfg(8, op(0, 12));
        alt_w = m_mem[7] ^ 24'h808080;
        run(4'b1010, mdl(4'b1010), 10, 0, 1);
        run(4'b1010, mdl(4'b1010), 10, 0, 0);
        run(4'b0101, mdl(4'b0101), 10, 0, 0);

        cfg(8, op(0, 12));
        @(negedge clk);
        pi = 4'b0110; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_vld",  32'(res_valid), 32'(0));
        chk("arst_err",  32'(err), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_len = 0; m_po = '0;
        run(4'b1111, mdl(4'b1111), 2, 0, 0);
        cfg(8, op(0, 12));
        run(4'b0110, mdl(4'b0110), 10, 0, 0);

        for (int r = 0; r < 3; r++) begin
            ln = int'($urandom_range(2, 8));
            for (int k = 0; k < ln; k++) begin
                prog(k, {op(1'($urandom_range(0, 1)), int'($urandom_range(0, 4 + k))),
                         op(1'($urandom_range(0, 1)), int'($urandom_range(0, 4 + k))),
                         op(1'($urandom_range(0, 1)), int'($urandom_range(0, 4 + k)))});
            end
            cfg(ln, op(1'($urandom_range(0, 1)), int'($urandom_range(0, 4 + ln))));
            for (int t = 0; t < 3; t++) begin
                pv = 4'($urandom_range(0, 15));
                run(pv, mdl(pv), ln + 2, 0, 0);
            end
        end

        chk("q_empty", 32'(q_exp.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
